// File: rtl/lsu_pkg.sv
// Shared types and byte-lane helpers for the load/store unit.
// Sizes follow the core encoding; the lane masks assume 64-bit memory words.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_e;

   localparam int BYTE_W = 8;
   localparam int LANE_W = 3;

   localparam logic [63:0] LANE_MASK_B = 64'h0000_0000_0000_00FF;
   localparam logic [63:0] LANE_MASK_H = 64'h0000_0000_0000_FFFF;
   localparam logic [63:0] LANE_MASK_W = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] LANE_MASK_D = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [63:0] size_mask(input size_e sz);
      case (sz)
         SZ_B:    return LANE_MASK_B;
         SZ_H:    return LANE_MASK_H;
         SZ_W:    return LANE_MASK_W;
         default: return LANE_MASK_D;
      endcase
   endfunction

   // An access is aligned when the offset bits below its size are all zero.
   function automatic logic is_aligned(input logic [LANE_W-1:0] off, input size_e sz);
      case (sz)
         SZ_B:    return 1'b1;
         SZ_H:    return (off[0] == 1'b0);
         SZ_W:    return (off[1:0] == 2'b00);
         default: return (off == 3'b000);
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a load lane and merges store bytes
// into an old memory word, little-endian within the 64-bit word.
module lsu_byte_lane
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_data,
   input  logic [LANE_W-1:0] offset,
   input  size_e             size,
   input  logic              is_unsigned,
   output logic [DATA_W-1:0] ext_data,
   output logic [DATA_W-1:0] merged
);

   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                 input logic [LANE_W-1:0] off,
                                                 input size_e             sz,
                                                 input logic              uns);
      logic [DATA_W-1:0]        lane;
      logic signed [DATA_W-1:0] ext;
      lane = word >> {off, 3'b000};
      case (sz)
         SZ_B:    ext = {{(DATA_W-8){~uns & lane[7]}}, lane[7:0]};
         SZ_H:    ext = {{(DATA_W-16){~uns & lane[15]}}, lane[15:0]};
         SZ_W:    ext = {{(DATA_W-32){~uns & lane[31]}}, lane[31:0]};
         default: ext = lane;
      endcase
      return ext;
   endfunction

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] nd,
                                               input logic [LANE_W-1:0] off,
                                               input size_e             sz);
      logic [DATA_W-1:0] mask;
      mask = DATA_W'(size_mask(sz)) << {off, 3'b000};
      return (old_w & ~mask) | ((nd << {off, 3'b000}) & mask);
   endfunction

   assign ext_data = extract(old_word, offset, size, is_unsigned);
   assign merged   = merge(old_word, new_data, offset, size);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store requester for a 64-bit word-indexed data memory:
// extends loads, read-modify-writes sub-doubleword stores, rejects misaligned.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_misaligned,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state;
   size_e             size_q;
   logic              we_q;
   logic              uns_q;
   logic [LANE_W-1:0] off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] ext_data;
   logic [DATA_W-1:0] merged;

   size_e             req_sz;
   logic [LANE_W-1:0] req_off;
   logic              misaligned;

   assign req_sz     = size_e'(req_size);
   assign req_off    = req_addr[LANE_W-1:0];
   assign misaligned = ~is_aligned(req_off, req_sz);

   // Request fields are pure data; they are only meaningful after acceptance.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         we_q    <= req_we;
         size_q  <= req_sz;
         uns_q   <= req_unsigned;
         off_q   <= req_off;
         wdata_q <= req_wdata;
      end
   end

   lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
      .old_word    (mem_rdata),
      .new_data    (wdata_q),
      .offset      (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .ext_data    (ext_data),
      .merged      (merged)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  mem_addr  <= DATA_W'(req_addr >> LANE_W);
                  if (misaligned) begin
                     resp_valid      <= 1'b1;
                     resp_misaligned <= 1'b1;
                     resp_rdata      <= '0;
                     state           <= RESP;
                  end else if (req_we && req_sz == SZ_D) begin
                     mem_wdata <= req_wdata;
                     mem_we    <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            // mem_rdata is valid here because mem_addr was registered at acceptance.
            READ: begin
               if (we_q) begin
                  mem_wdata <= merged;
                  mem_we    <= 1'b1;
                  state     <= WRITE;
               end else begin
                  resp_rdata <= ext_data;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            WRITE: begin
               mem_we     <= 1'b0;
               resp_rdata <= '0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid      <= 1'b0;
               resp_misaligned <= 1'b0;
               resp_rdata      <= '0;
               req_ready       <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle requester that issues loads and stores from the core datapath to the 64-bit word-addressed data memory. It converts byte addresses and access sizes into word-indexed memory accesses. Loads are sign- or zero-extended; sub-doubleword stores use read-modify-write; misaligned accesses are rejected without touching memory. It sits between the execute stage and the data memory, on the initiator side of the memory's MemWrite/Address/Writedata/Readdata interface.

## Interface
- DATA_W, default 64: data width of core and memory words.
- ADDR_W, default 64: byte address width from the core.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  valid with resp_valid; access was not size-aligned.
- mem_we  out  1  drives memory MemWrite.
- mem_addr  out  DATA_W  word index = req_addr >> 3, zero-extended.
- mem_wdata  out  DATA_W  drives memory Writedata.
- mem_rdata  in  DATA_W  memory Readdata; combinational from mem_addr.

## Operation
- States: IDLE, READ, WRITE, RESP.
- req_ready = (state == IDLE). A request is accepted on req_valid & req_ready. All request fields are latched at acceptance.
- Alignment check: byte always aligned; half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
  - Misaligned: IDLE→RESP with resp_misaligned=1. No memory access; mem_we stays 0.
- Load: IDLE→READ→RESP.
  - In READ, mem_addr holds the word index and mem_rdata is registered.
  - The lane at byte offset addr[2:0] (little-endian) is extracted and extended per req_unsigned.
- Store, size 11: IDLE→WRITE→RESP. mem_wdata = req_wdata.
- Store, size < 11: IDLE→READ→WRITE→RESP.
  - READ registers the old word.
  - WRITE drives mem_we=1 with the old word, where the addressed bytes are replaced by the low bytes of req_wdata.
- mem_we is 1 only in WRITE, for exactly one cycle per store.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response backpressure.
- Addresses beyond memory depth are passed through unchanged; wrap is the memory's behaviour.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_misaligned 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset asserted mid-operation aborts immediately and asynchronously.
  - mem_we drops in the same cycle. No partial write occurs after reset assertion.
  - No response is produced for the aborted request.
- Latency from acceptance edge to resp_valid:
  - load: 2 cycles
  - full store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- A new request can be accepted in the cycle after resp_valid. Throughput is 1 request per 2–4 cycles.
- req_valid while not ready is ignored. The core must hold the request until accepted.

## Structure
- Package lsu_pkg holds:
  - size enum: SZ_B, SZ_H, SZ_W, SZ_D
  - state enum: IDLE, READ, WRITE, RESP
  - byte-lane helper constants
- One combinational sub-module, lsu_byte_lane, with two functions:
  - extract: word, offset, size, unsigned → extended data
  - merge: old word, new data, offset, size → written word
- FSM and registers live in load_store_unit.

## Test plan
- Memory preloaded with word 2 = 0x8877665544332211. Load byte at addr 0x17, signed → resp_rdata 0xFFFFFFFFFFFFFF88 two cycles after accept. The same load unsigned → 0x88.
- Store half 0xBEEF to addr 0x12 over word 2 = 0x8877665544332211 → one mem_we pulse at index 2 with 0x88776655BEEF2211. Response 3 cycles after accept.
- Store double 0x0123456789ABCDEF to addr 0x08 → mem_we at index 1 in the cycle after accept; no READ state visited.
- Load word from addr 0x06 → resp_misaligned=1 one cycle after accept, resp_rdata=0, mem_we never asserted.
- Assert reset during WRITE of a sub-word store → mem_we drops to 0 immediately, memory unchanged, req_ready=1, no resp_valid.
- Back-to-back: load issued the cycle after resp_valid of a store to the same byte address returns the stored value.
